// File: rtl/serial_pkg.sv
// rtl/serial_pkg.sv - shared types and constants for the serial transmitter
//
// Purpose: state encoding, line levels and default parameter values used by
//          serial_tx and baud_counter.
// Optional feature: SERIAL_TX_PARITY_EN adds the PARITY_BIT state.
package serial_pkg;

  localparam int DATA_W_DEF   = 8;
  localparam int BAUD_DIV_DEF = 4;

  localparam logic LINE_IDLE = 1'b1;
  localparam logic START_LVL = 1'b0;
  localparam logic STOP_LVL  = 1'b1;

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    START_BIT  = 3'd1,
    DATA_BITS  = 3'd2,
`ifdef SERIAL_TX_PARITY_EN
    PARITY_BIT = 3'd3,
`endif
    STOP_BIT   = 3'd4
  } tx_state_t;

endpackage

// File: rtl/baud_counter.sv
// rtl/baud_counter.sv - bit-period down-counter for the serial transmitter
//
// Purpose: counts BAUD_DIV cycles per serial bit; tick marks the last cycle
//          of the current bit period.
// Ports:
//   Clock  in  sole clock
//   Reset  in  synchronous active-low reset (counter cleared to 0)
//   reload in  restart the period (count <= BAUD_DIV-1) at a bit boundary
//   tick   out high on the last cycle of each bit period
module baud_counter
  import serial_pkg::*;
#(
  parameter int BAUD_DIV = BAUD_DIV_DEF
) (
  input  logic Clock,
  input  logic Reset,
  input  logic reload,
  output logic tick
);

  localparam logic [7:0] LAST_CNT = 8'(BAUD_DIV - 1);

  logic [7:0] count_q, count_d;

  // Saturates at zero so BAUD_DIV=1 (count always 0, tick always high)
  // never wraps.
  always_comb begin
    count_d = count_q;
    if (reload) begin
      count_d = LAST_CNT;
    end else if (count_q != 8'd0) begin
      count_d = count_q - 8'd1;
    end
  end

  always_ff @(posedge Clock) begin
    if (!Reset) begin
      count_q <= 8'd0;
    end else begin
      count_q <= count_d;
    end
  end

  assign tick = (count_q == 8'd0);

endmodule

// File: rtl/serial_tx.sv
// rtl/serial_tx.sv - parallel-in, LSB-first serial transmitter
//
// Purpose: frames DATA_W-bit payloads as start bit, data bits (LSB first),
//          optional even parity bit, stop bit; each bit lasts BAUD_DIV cycles.
// Optional feature: define SERIAL_TX_PARITY_EN to insert the parity bit.
// Ports:
//   Clock  in   sole clock
//   Reset  in   synchronous active-low reset
//   Start  in   transmit request, honoured only in IDLE
//   Din    in   payload, captured when Start is accepted
//   SerOut out  registered serial line, idle high
//   Busy   out  high while a frame is in progress
//   Done   out  one-cycle pulse in the first IDLE cycle after the stop bit
module serial_tx
  import serial_pkg::*;
#(
  parameter int DATA_W   = DATA_W_DEF,
  parameter int BAUD_DIV = BAUD_DIV_DEF
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic              Start,
  input  logic [DATA_W-1:0] Din,
  output logic              SerOut,
  output logic              Busy,
  output logic              Done
);

  localparam int             IDX_W    = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_W - 1);

  tx_state_t         state_q, state_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic              ser_q, ser_d;
  logic              done_q, done_d;
  logic              reload;
  logic              tick;
`ifdef SERIAL_TX_PARITY_EN
  logic              parity_q, parity_d;
`endif

  baud_counter #(
    .BAUD_DIV(BAUD_DIV)
  ) u_baud (
    .Clock (Clock),
    .Reset (Reset),
    .reload(reload),
    .tick  (tick)
  );

  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    idx_d   = idx_q;
    done_d  = 1'b0;
    reload  = 1'b0;
`ifdef SERIAL_TX_PARITY_EN
    parity_d = parity_q;
`endif

    case (state_q)
      IDLE: begin
        if (Start) begin
          state_d = START_BIT;
          shift_d = Din;
          idx_d   = '0;
          reload  = 1'b1;
`ifdef SERIAL_TX_PARITY_EN
          parity_d = ^Din;
`endif
        end
      end
      START_BIT: begin
        if (tick) begin
          state_d = DATA_BITS;
          reload  = 1'b1;
        end
      end
      DATA_BITS: begin
        if (tick) begin
          reload = 1'b1;
          if (idx_q == LAST_IDX) begin
`ifdef SERIAL_TX_PARITY_EN
            state_d = PARITY_BIT;
`else
            state_d = STOP_BIT;
`endif
          end else begin
            idx_d   = idx_q + 1'b1;
            shift_d = shift_q >> 1;
          end
        end
      end
`ifdef SERIAL_TX_PARITY_EN
      PARITY_BIT: begin
        if (tick) begin
          state_d = STOP_BIT;
          reload  = 1'b1;
        end
      end
`endif
      STOP_BIT: begin
        if (tick) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // The line level is derived from the next state so SerOut can be a
    // plain register that changes exactly on the bit boundary.
    case (state_d)
      START_BIT:  ser_d = START_LVL;
      DATA_BITS:  ser_d = shift_d[0];
`ifdef SERIAL_TX_PARITY_EN
      PARITY_BIT: ser_d = parity_d;
`endif
      STOP_BIT:   ser_d = STOP_LVL;
      default:    ser_d = LINE_IDLE;
    endcase
  end

  always_ff @(posedge Clock) begin
    if (!Reset) begin
      state_q <= IDLE;
      shift_q <= '0;
      idx_q   <= '0;
      ser_q   <= LINE_IDLE;
      done_q  <= 1'b0;
`ifdef SERIAL_TX_PARITY_EN
      parity_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      idx_q   <= idx_d;
      ser_q   <= ser_d;
      done_q  <= done_d;
`ifdef SERIAL_TX_PARITY_EN
      parity_q <= parity_d;
`endif
    end
  end

  assign SerOut = ser_q;
  assign Busy   = (state_q != IDLE);
  assign Done   = done_q;

endmodule
